phase_to_pwm: RTL and testbench

- Downstream stage of the 32-bit phase accumulator in the PWM audio path.
- Each clock, converts the accumulator phase into an N-bit waveform sample: sawtooth, square, triangle or silence.
- Latches that sample as the duty value at each PWM frame boundary and drives a single-bit PWM output.
- Emits a frame-start strobe that is usable as the accumulator's cycle enable.

---
 rtl/phase_to_pwm.sv | 95 +++++++++
 tb/tb_phase_to_pwm.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/phase_to_pwm.sv
// Phase-to-PWM stage: maps accumulator phase to a waveform sample and
// modulates it onto a single-bit PWM output with frame-aligned duty updates.
module phase_to_pwm #(
    parameter int PWM_BITS = 8
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic [31:0]         i_phase,
    input  logic [1:0]          i_wave_sel,
    input  logic                i_enable,
    output logic [PWM_BITS-1:0] o_sample,
    output logic                o_pwm,
    output logic                o_cycle
);

    localparam int N = PWM_BITS;
    localparam logic [N-1:0] CNT_ONE = N'(1);
    localparam logic [N-1:0] CNT_MAX = '1;
    localparam logic [N-1:0] MID     = {1'b1, {(N-1){1'b0}}};

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t       state_q;
    logic [N-1:0] sample_q, sample_d;
    logic [N-1:0] count_q;
    logic [N-1:0] duty_q;

    logic [N-1:0] saw;
    logic [N-1:0] tri_half;
    logic         unused_phase;

    assign saw          = i_phase[31 -: N];
    assign tri_half     = i_phase[30 -: N];
    assign unused_phase = ^i_phase[30-N:0];

    always_comb begin
        sample_d = '0;
        unique case (i_wave_sel)
            2'b00: sample_d = saw;
            2'b01: sample_d = {N{i_phase[31]}};
            2'b10: sample_d = i_phase[31] ? ~tri_half : tri_half;
            2'b11: sample_d = MID;
            default: sample_d = '0;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            sample_q <= '0;
        end else begin
            sample_q <= sample_d;
        end
    end

    // Frames always run to completion; enable is only honoured at the wrap.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= IDLE;
            count_q <= '0;
            duty_q  <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    count_q <= '0;
                    if (i_enable) begin
                        state_q <= RUN;
                        duty_q  <= sample_q;
                    end
                end
                RUN: begin
                    count_q <= count_q + CNT_ONE;
                    if (count_q == CNT_MAX) begin
                        if (i_enable) begin
                            duty_q <= sample_q;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    count_q <= '0;
                end
            endcase
        end
    end

    assign o_sample = sample_q;
    assign o_pwm    = (state_q == RUN) && (count_q < duty_q);
    assign o_cycle  = (state_q == RUN) && (count_q == '0);

endmodule

// File: tb/tb_phase_to_pwm.sv
// Bench for phase_to_pwm: frame-level reference model with per-cycle
// comparison plus directed scenarios with literal expectations.
module tb_phase_to_pwm;

    localparam int N = 8;
    localparam int FRAME = 1 << N;
    localparam logic [31:0] DELTA = 32'd75591;

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   phase_reg;
    logic [31:0]   phase;
    logic [1:0]    wsel;
    logic          en;
    logic [N-1:0]  o_sample;
    logic          o_pwm;
    logic          o_cycle;

    logic          use_acc;
    logic          acc_load;
    logic [31:0]   acc_init;
    logic [31:0]   acc;
    int            cycn;
    int            checks;
    int            failures;

    phase_to_pwm #(.PWM_BITS(N)) dut (
        .i_clk      (clk),
        .i_reset    (rst),
        .i_phase    (phase),
        .i_wave_sel (wsel),
        .i_enable   (en),
        .o_sample   (o_sample),
        .o_pwm      (o_pwm),
        .o_cycle    (o_cycle)
    );

    always #5 clk = ~clk;

    assign phase = use_acc ? acc : phase_reg;

    always @(posedge clk) begin
        cycn <= cycn + 1;
        if (acc_load) acc <= acc_init;
        else if (use_acc && o_cycle) acc <= acc + DELTA;
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Waveform rule evaluated with plain arithmetic on the phase value.
    function automatic longint wave(input logic [31:0] ph, input logic [1:0] s);
        longint unsigned full = longint'(FRAME);
        longint unsigned p    = longint'(ph);
        longint unsigned half = 64'h8000_0000;
        longint unsigned t;
        t = (p / (64'd1 << (31 - N))) % full;
        case (s)
            2'd0: return p / (64'd1 << (32 - N));
            2'd1: return (p >= half) ? full - 1 : 0;
            2'd2: return (p >= half) ? full - 1 - t : t;
            default: return full / 2;
        endcase
    endfunction

    // Reference: whole frames of FRAME clocks, duty chosen at frame start.
    longint m_sample, m_duty;
    int     m_pos;
    bit     m_run;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_sample <= 0;
            m_duty   <= 0;
            m_pos    <= 0;
            m_run    <= 0;
        end else begin
            m_sample <= wave(phase, wsel);
            if (!m_run) begin
                if (en) begin
                    m_run  <= 1;
                    m_pos  <= 0;
                    m_duty <= m_sample;
                end
            end else if (m_pos == FRAME - 1) begin
                m_pos <= 0;
                if (en) m_duty <= m_sample;
                else m_run <= 0;
            end else begin
                m_pos <= m_pos + 1;
            end
        end
    end

    always @(negedge clk) begin
        chk("model_sample", longint'(o_sample), m_sample);
        chk("model_pwm", longint'(o_pwm), longint'(m_run && (m_pos < m_duty)));
        chk("model_cycle", longint'(o_cycle), longint'(m_run && m_pos == 0));
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_cycle();
        int k = 0;
        do begin
            tick(1);
            k++;
        end while (!o_cycle && k < 2000);
        if (!o_cycle) chk("cycle_timeout", 0, 1);
    endtask

    // From a strobe clock, measure one frame's length and high count.
    task automatic frame(output int highs, output int len);
        highs = 0;
        len   = 0;
        do begin
            highs += int'(o_pwm);
            len++;
            tick(1);
        end while (!o_cycle && len < 1000);
    endtask

    task automatic run_wave(input string name, input logic [31:0] ph,
                            input logic [1:0] s, input int exp_s, input int exp_h);
        int h, l;
        phase_reg = ph;
        wsel      = s;
        tick(2);
        chk({name, "_sample"}, longint'(o_sample), longint'(exp_s));
        wait_cycle();
        frame(h, l);
        chk({name, "_highs"}, h, exp_h);
        chk({name, "_len"}, l, FRAME);
    endtask

    initial begin
        int h, l, t0, cnt;
        checks    = 0;
        failures  = 0;
        cycn      = 0;
        rst       = 1'b1;
        en        = 1'b0;
        phase_reg = 32'h0;
        wsel      = 2'd0;
        use_acc   = 1'b0;
        acc_load  = 1'b0;
        acc_init  = 32'h0;
        acc       = 32'h0;
        #2;
        chk("reset_sample", longint'(o_sample), 0);
        chk("reset_pwm", longint'(o_pwm), 0);
        chk("reset_cycle", longint'(o_cycle), 0);
        tick(2);
        rst = 1'b0;
        tick(1);
        chk("idle_cycle", longint'(o_cycle), 0);

        phase_reg = 32'h8000_0000;
        tick(2);
        en = 1'b1;
        tick(1);
        chk("saw_sample", longint'(o_sample), 8'h80);
        chk("saw_first_cycle", longint'(o_cycle), 1);
        frame(h, l);
        chk("saw_highs", h, 128);
        chk("saw_len", l, 256);
        frame(h, l);
        chk("saw_len2", l, 256);

        tick(50);
        chk("pre_reset_pwm", longint'(o_pwm), 1);
        #2 rst = 1'b1;
        #1;
        chk("async_pwm", longint'(o_pwm), 0);
        chk("async_cycle", longint'(o_cycle), 0);
        chk("async_sample", longint'(o_sample), 0);
        tick(1);
        rst = 1'b0;
        chk("post_reset_idle", longint'(o_cycle), 0);
        tick(1);
        chk("post_reset_start", longint'(o_cycle), 1);

        run_wave("square_hi", 32'h8000_0000, 2'd1, 8'hFF, 255);
        run_wave("square_lo", 32'h7FFF_FFFF, 2'd1, 8'h00, 0);
        run_wave("triangle", 32'hC000_0000, 2'd2, 8'h7F, 127);
        run_wave("silence", 32'h1234_5678, 2'd3, 8'h80, 128);
        run_wave("saw80", 32'h8000_0000, 2'd0, 8'h80, 128);

        phase_reg = 32'h2000_0000;
        wsel      = 2'd0;
        tick(2);
        wait_cycle();
        fork
            begin
                tick(10);
                phase_reg = 32'hE000_0000;
            end
        join_none
        frame(h, l);
        chk("midframe_cur", h, 8'h20);
        frame(h, l);
        chk("midframe_next", h, 8'hE0);

        wait_cycle();
        fork
            begin
                tick(100);
                en = 1'b0;
            end
        join_none
        tick(255);
        chk("disable_last_clock_run", longint'(o_cycle), 0);
        tick(1);
        chk("disable_idle_cycle", longint'(o_cycle), 0);
        chk("disable_idle_pwm", longint'(o_pwm), 0);
        cnt = 0;
        repeat (300) begin
            tick(1);
            cnt += int'(o_cycle);
        end
        chk("disable_no_strobe", cnt, 0);

        en = 1'b1;
        wait_cycle();
        t0 = cycn;
        fork
            begin
                tick(100);
                en = 1'b0;
                tick(100);
                en = 1'b1;
            end
        join_none
        wait_cycle();
        chk("reenable_period", cycn - t0, 256);

        acc_init = 32'h30FF_0000;
        acc_load = 1'b1;
        tick(1);
        acc_load = 1'b0;
        use_acc  = 1'b1;
        wsel     = 2'd0;
        tick(3);
        wait_cycle();
        for (int f = 0; f < 10; f++) begin
            int exp_h;
            exp_h = int'(acc >> 24);
            frame(h, l);
            chk("acc_frame_highs", h, exp_h);
            chk("acc_frame_len", l, 256);
        end
        chk("acc_advanced", longint'(acc >> 24), 8'h31);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
